dma_operand_sequencer: RTL and testbench
========================================

Name: dma_operand_sequencer

Overview:
- Parametrised successor of the single-command RSA top-level controller.
- Loads NUM_OPS operands of DATA_W bits over the DMA read channel, pulses a compute core and waits for its completion, then writes the result back over the DMA write channel.
- Adds three behaviours the previous controller lacks: a per-operand reload mask (cached operands are skipped), a watchdog timeout, and an ERROR state for DMA faults.
- Sits between the CPU register file / DMA engine and any exponentiation or multiplication core.

Parameters:
- DATA_W, 1024: operand, result and DMA beat width.
- NUM_OPS, 5: number of operands loaded per run (1..16).
- TIMEOUT_CYCLES, 2**20: watchdog limit per wait phase.
- TO_W, 21: watchdog counter width; must satisfy 2**TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cmd  in  32  bit0 = go; bits[8+NUM_OPS-1:8] = reload mask; cmd==0 means idle.
- op_addr  in  32*NUM_OPS  source address of operand i in slice [32i+31:32i].
- tx_addr  in  32  result destination address.
- status  out  32  {20'b0, state[3:0], 4'b0, timeout, dma_err, is_idle, is_done}.
- dma_rx_data  in  DATA_W  read data.
- dma_rx_address  out  32  read address.
- dma_rx_start  out  1  read request.
- dma_tx_data  out  DATA_W  write data (result register).
- dma_tx_address  out  32  equals tx_addr.
- dma_tx_start  out  1  write request.
- dma_done  in  1  transfer complete pulse.
- dma_idle  in  1  DMA engine idle.
- dma_error  in  1  DMA fault.
- core_start  out  1  one-cycle compute start pulse.
- core_done  in  1  compute complete pulse.
- core_result  in  DATA_W  compute result.
- operands  out  DATA_W*NUM_OPS  operand registers, operand i in slice i.

Behaviour:
- Reset values (asynchronous): state=IDLE, op_idx=0, all start strobes 0, dma_rx_address 0, status flags 0, watchdog 0. Operand and result registers are not reset.
- States and transitions:
  - IDLE: if cmd[0]=1, latch the mask, clear the sticky flags, set op_idx=0 -> RX_REQ.
  - RX_REQ, mask[op_idx]=0: no request is issued; op_idx++ in one cycle; after the last operand -> COMPUTE.
  - RX_REQ, mask[op_idx]=1: dma_rx_start=1 and dma_rx_address=op_addr[op_idx], both registered and held until dma_idle=0 -> RX_WAIT.
  - RX_WAIT: on dma_done, operands[op_idx] <= dma_rx_data in that cycle; then if op_idx==NUM_OPS-1 -> COMPUTE, else op_idx++ -> RX_REQ.
  - COMPUTE: core_start=1 for exactly one cycle -> COMPUTE_WAIT.
  - COMPUTE_WAIT: on core_done, result <= core_result -> TX_REQ. The result is visible on dma_tx_data the next cycle.
  - TX_REQ: dma_tx_start=1 until dma_idle=0 -> TX_WAIT.
  - TX_WAIT: on dma_done -> DONE.
  - DONE: is_done=1; stays until cmd==0 -> IDLE. This prevents re-triggering while go is still set.
  - ERROR: flags held; stays until cmd==0 -> IDLE.
- Mask is all zero: no DMA reads; IDLE -> RX_REQ -> COMPUTE after NUM_OPS skip cycles. Cached operands are used unchanged.
- dma_error in RX_REQ/RX_WAIT/TX_REQ/TX_WAIT: dma_err=1 -> ERROR. The operand being loaded is not written.
- Watchdog:
  - Clears on every state change.
  - Counts in RX_REQ, RX_WAIT, COMPUTE_WAIT, TX_REQ and TX_WAIT.
  - Reaching TIMEOUT_CYCLES sets timeout=1 -> ERROR.
  - Timeout and dma_error in the same cycle: both flags set.
- Simultaneous dma_done and dma_error: the error wins; no capture.
- cmd deasserted mid-run: ignored; the run completes. Only reset aborts a run.
- Reset mid-transfer: the state returns to IDLE asynchronously and strobes drop immediately. Partially loaded operands keep whatever was captured.
- is_idle = (state==IDLE).

Decomposition:
- Package dma_seq_pkg holds:
  - the state enum (4-bit);
  - status bit positions;
  - the CMD_GO bit and MASK_LSB=8 constants.
- One sub-module, seq_watchdog: counter with clear/enable inputs and an expired output, parametrised by TIMEOUT_CYCLES and TO_W.

Test Plan:
- NUM_OPS=5, cmd=0x1F01, DMA model returns op i = i+1 with done 3 cycles after start. Expected: five reads at op_addr[0..4]; core_start pulses once; core_result=0xABCD is written to tx_addr; status=DONE (bit0); then cmd=0 -> status bit1.
- Second run with cmd=0x0401. Expected: only op 2 is fetched; ops 0,1,3,4 retain their previous values; the result is written once.
- cmd=0x0001 (mask 0). Expected: no dma_rx_start; core_start 5 cycles after go; TX proceeds normally.
- dma_error asserted during the op-3 RX_WAIT. Expected: state ERROR, status bit2=1, operands[3] unchanged, no core_start; cmd=0 returns to IDLE.
- TIMEOUT_CYCLES=16 and core_done never arrives. Expected: ERROR exactly 16 cycles after entering COMPUTE_WAIT, status bit3=1.
- reset pulsed in TX_WAIT. Expected: dma_tx_start=0 and state IDLE within the same cycle; the next go with mask 0 completes normally.

Source files
------------

// File: rtl/dma_seq_pkg.sv
// Shared types and constants for the DMA operand sequencer.
package dma_seq_pkg;

    // Sequencer states; the encoding is exported through status[11:8].
    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_RX_REQ       = 4'd1,
        ST_RX_WAIT      = 4'd2,
        ST_COMPUTE      = 4'd3,
        ST_COMPUTE_WAIT = 4'd4,
        ST_TX_REQ       = 4'd5,
        ST_TX_WAIT      = 4'd6,
        ST_DONE         = 4'd7,
        ST_ERROR        = 4'd8
    } state_t;

    // Status word bit positions.
    localparam int STAT_DONE      = 0;
    localparam int STAT_IDLE      = 1;
    localparam int STAT_DMA_ERR   = 2;
    localparam int STAT_TIMEOUT   = 3;
    localparam int STAT_STATE_LSB = 8;

    // Command word fields.
    localparam int CMD_GO   = 0;
    localparam int MASK_LSB = 8;

endpackage

// File: rtl/dma_operand_sequencer_if.sv
// DMA engine and compute core handshake bundle seen by the sequencer.
interface dma_operand_sequencer_if #(
    parameter int DATA_W = 1024
);
    logic [DATA_W-1:0] dma_rx_data;
    logic [31:0]       dma_rx_address;
    logic              dma_rx_start;
    logic [DATA_W-1:0] dma_tx_data;
    logic [31:0]       dma_tx_address;
    logic              dma_tx_start;
    logic              dma_done;
    logic              dma_idle;
    logic              dma_error;
    logic              core_start;
    logic              core_done;
    logic [DATA_W-1:0] core_result;

    modport master (
        input  dma_rx_data, dma_done, dma_idle, dma_error, core_done, core_result,
        output dma_rx_address, dma_rx_start, dma_tx_data, dma_tx_address,
               dma_tx_start, core_start
    );

    modport slave (
        output dma_rx_data, dma_done, dma_idle, dma_error, core_done, core_result,
        input  dma_rx_address, dma_rx_start, dma_tx_data, dma_tx_address,
               dma_tx_start, core_start
    );
endinterface

// File: rtl/seq_watchdog.sv
// Phase watchdog: counts enabled cycles and flags the last permitted one.
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int TO_W           = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] count;

    // Cycle counter for the current wait phase, restarted on every phase change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Expiry fires during the TIMEOUT_CYCLES-th cycle so the exit edge lands exactly on the limit.
    assign expired = enable && (count == LAST);
endmodule

// File: rtl/dma_operand_sequencer.sv
// Loads masked operands over DMA, runs the compute core, writes the result back.
module dma_operand_sequencer
    import dma_seq_pkg::*;
#(
    parameter int DATA_W         = 1024,
    parameter int NUM_OPS        = 5,
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int TO_W           = 21
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [31:0]                     cmd,
    input  logic [NUM_OPS-1:0][31:0]        op_addr,
    input  logic [31:0]                     tx_addr,
    output logic [31:0]                     status,
    output logic [NUM_OPS-1:0][DATA_W-1:0]  operands,
    dma_operand_sequencer_if.master         bus
);
    localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

    state_t                          state, state_d;
    logic [IDX_W-1:0]                op_idx, op_idx_d;
    logic [NUM_OPS-1:0]              mask, mask_d;
    logic                            rx_start, tx_start, core_start;
    logic                            rx_start_d, tx_start_d, core_start_d;
    logic [31:0]                     rx_address;
    logic                            err_flag, to_flag;
    logic                            capture_op, capture_res, clear_flags, set_err, set_to;
    logic                            wd_clear, wd_en, wd_expired, dma_phase;
    logic [NUM_OPS-1:0][DATA_W-1:0]  op_regs;
    logic [DATA_W-1:0]               result;

    seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    // Next-state decode; faults and watchdog expiry pre-empt normal progress.
    always_comb begin
        state_d     = state;
        op_idx_d    = op_idx;
        mask_d      = mask;
        capture_op  = 1'b0;
        capture_res = 1'b0;
        clear_flags = 1'b0;
        set_err     = 1'b0;
        set_to      = 1'b0;
        wd_en       = state inside {ST_RX_REQ, ST_RX_WAIT, ST_COMPUTE_WAIT, ST_TX_REQ, ST_TX_WAIT};
        dma_phase   = state inside {ST_RX_REQ, ST_RX_WAIT, ST_TX_REQ, ST_TX_WAIT};

        if (wd_en && (wd_expired || (dma_phase && bus.dma_error))) begin
            set_to  = wd_expired;
            set_err = dma_phase && bus.dma_error;
            state_d = ST_ERROR;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd[CMD_GO]) begin
                        mask_d      = cmd[MASK_LSB +: NUM_OPS];
                        clear_flags = 1'b1;
                        op_idx_d    = '0;
                        state_d     = ST_RX_REQ;
                    end
                end
                ST_RX_REQ: begin
                    if (!mask[op_idx]) begin
                        if (op_idx == LAST_IDX) state_d = ST_COMPUTE;
                        else                    op_idx_d = op_idx + 1'b1;
                    end else if (!bus.dma_idle) begin
                        state_d = ST_RX_WAIT;
                    end
                end
                ST_RX_WAIT: begin
                    if (bus.dma_done) begin
                        capture_op = 1'b1;
                        if (op_idx == LAST_IDX) begin
                            state_d = ST_COMPUTE;
                        end else begin
                            op_idx_d = op_idx + 1'b1;
                            state_d  = ST_RX_REQ;
                        end
                    end
                end
                ST_COMPUTE:      state_d = ST_COMPUTE_WAIT;
                ST_COMPUTE_WAIT: begin
                    if (bus.core_done) begin
                        capture_res = 1'b1;
                        state_d     = ST_TX_REQ;
                    end
                end
                ST_TX_REQ:       if (!bus.dma_idle) state_d = ST_TX_WAIT;
                ST_TX_WAIT:      if (bus.dma_done)  state_d = ST_DONE;
                ST_DONE,
                ST_ERROR:        if (cmd == 32'd0)  state_d = ST_IDLE;
                default:         state_d = ST_IDLE;
            endcase
        end

        wd_clear     = (state_d != state) || (op_idx_d != op_idx);
        rx_start_d   = (state_d == ST_RX_REQ) && mask_d[op_idx_d];
        tx_start_d   = (state_d == ST_TX_REQ);
        core_start_d = (state_d == ST_COMPUTE);
    end

    // Control registers; strobes are registered from the next state so they drop with reset at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_idx     <= '0;
            mask       <= '0;
            rx_start   <= 1'b0;
            tx_start   <= 1'b0;
            core_start <= 1'b0;
            rx_address <= '0;
            err_flag   <= 1'b0;
            to_flag    <= 1'b0;
        end else begin
            state      <= state_d;
            op_idx     <= op_idx_d;
            mask       <= mask_d;
            rx_start   <= rx_start_d;
            tx_start   <= tx_start_d;
            core_start <= core_start_d;
            if (rx_start_d)  rx_address <= op_addr[op_idx_d];
            if (clear_flags) begin
                err_flag <= 1'b0;
                to_flag  <= 1'b0;
            end
            if (set_err) err_flag <= 1'b1;
            if (set_to)  to_flag  <= 1'b1;
        end
    end

    // Operand cache and result register; unreset so cached operands survive between runs.
    always_ff @(posedge clk) begin
        if (capture_op)  op_regs[op_idx] <= bus.dma_rx_data;
        if (capture_res) result          <= bus.core_result;
    end

    // Status word assembly.
    always_comb begin
        status                        = '0;
        status[STAT_STATE_LSB +: 4]   = state;
        status[STAT_TIMEOUT]          = to_flag;
        status[STAT_DMA_ERR]          = err_flag;
        status[STAT_IDLE]             = (state == ST_IDLE);
        status[STAT_DONE]             = (state == ST_DONE);
    end

    assign bus.dma_rx_start   = rx_start;
    assign bus.dma_rx_address = rx_address;
    assign bus.dma_tx_start   = tx_start;
    assign bus.dma_tx_address = tx_addr;
    assign bus.dma_tx_data    = result;
    assign bus.core_start     = core_start;
    assign operands           = op_regs;
endmodule

// File: tb/tb_dma_operand_sequencer.sv
// Directed bench for dma_operand_sequencer with behavioural DMA and core responders.
module tb_dma_operand_sequencer;
    localparam int DATA_W         = 32;
    localparam int NUM_OPS        = 5;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int TO_W           = 5;

    logic                           clk = 1'b0;
    logic                           reset;
    logic [31:0]                    cmd;
    logic [31:0]                    tx_addr;
    logic [31:0]                    status;
    logic [NUM_OPS-1:0][31:0]       op_addr;
    logic [NUM_OPS-1:0][DATA_W-1:0] operands;

    dma_operand_sequencer_if #(.DATA_W(DATA_W)) bus();

    dma_operand_sequencer #(
        .DATA_W         (DATA_W),
        .NUM_OPS        (NUM_OPS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd      (cmd),
        .op_addr  (op_addr),
        .tx_addr  (tx_addr),
        .status   (status),
        .operands (operands),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [DATA_W-1:0] data_tab [NUM_OPS];
    int                err_op    = -1;
    bit                core_hang = 1'b0;
    int                rx_count  = 0;
    int                tx_count  = 0;
    int                core_pulses = 0;
    logic [31:0]       rx_log [$];
    logic [31:0]       tx_addr_seen;
    logic [DATA_W-1:0] tx_data_seen;

    // DMA responder: accepts a start, drops idle, returns done (or error) 3 cycles later.
    initial begin
        int  cnt;
        int  k;
        bit  busy;
        bit  err_now;
        cnt = 0; busy = 1'b0; err_now = 1'b0;
        bus.dma_idle = 1'b1; bus.dma_done = 1'b0; bus.dma_error = 1'b0; bus.dma_rx_data = '0;
        forever begin
            @(negedge clk);
            bus.dma_done  = 1'b0;
            bus.dma_error = 1'b0;
            if (busy) begin
                cnt++;
                if (cnt == 3) begin
                    if (err_now) bus.dma_error = 1'b1;
                    else         bus.dma_done  = 1'b1;
                end else if (cnt >= 4) begin
                    busy = 1'b0;
                    bus.dma_idle = 1'b1;
                end
            end else if (!reset && (bus.dma_rx_start || bus.dma_tx_start)) begin
                busy = 1'b1; cnt = 0; bus.dma_idle = 1'b0; err_now = 1'b0;
                if (bus.dma_rx_start) begin
                    rx_count++;
                    rx_log.push_back(bus.dma_rx_address);
                    k = -1;
                    for (int i = 0; i < NUM_OPS; i++) if (op_addr[i] == bus.dma_rx_address) k = i;
                    if (k >= 0) bus.dma_rx_data = data_tab[k];
                    err_now = (err_op >= 0) && (k == err_op);
                end else begin
                    tx_count++;
                    tx_addr_seen = bus.dma_tx_address;
                    tx_data_seen = bus.dma_tx_data;
                end
            end
        end
    end

    // Compute core responder: done pulse 4 cycles after start unless hung.
    initial begin
        int cnt;
        cnt = 0;
        bus.core_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.core_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) bus.core_done = 1'b1;
            end
            if (bus.core_start) begin
                core_pulses++;
                if (!core_hang) cnt = 4;
            end
        end
    end

    task automatic wait_state(input logic [3:0] st_a, input logic [3:0] st_b,
                              input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (status[11:8] == st_a || status[11:8] == st_b) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (status !== 32'h0000_0002) begin mismatched++; $display("FAIL reset_status: got %h need %h", status, 32'h2); end
        compared++;
        if (bus.dma_rx_start !== 1'b0 || bus.dma_tx_start !== 1'b0) begin mismatched++; $display("FAIL reset_dma_strobes: got %b%b need 00", bus.dma_rx_start, bus.dma_tx_start); end
        compared++;
        if (bus.core_start !== 1'b0) begin mismatched++; $display("FAIL reset_core_start: got %b need 0", bus.core_start); end
        compared++;
        if (bus.dma_rx_address !== 32'd0) begin mismatched++; $display("FAIL reset_rx_address: got %h need 0", bus.dma_rx_address); end
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (status !== 32'h0000_0002) begin mismatched++; $display("FAIL post_reset_idle: got %h need %h", status, 32'h2); end
    endtask

    task automatic test_full_load();
        int rx0, tx0, c0;
        bit ok;
        for (int i = 0; i < NUM_OPS; i++) data_tab[i] = DATA_W'(i + 1);
        bus.core_result = 32'h0000_ABCD;
        rx_log.delete();
        rx0 = rx_count; tx0 = tx_count; c0 = core_pulses;
        @(negedge clk) cmd = 32'h0000_1F01;
        wait_state(4'd7, 4'd7, 300, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL full_reach_done: status %h never reached DONE", status); end
        compared++;
        if (status !== 32'h0000_0701) begin mismatched++; $display("FAIL full_status: got %h need %h", status, 32'h701); end
        compared++;
        if (rx_count - rx0 !== 5) begin mismatched++; $display("FAIL full_rx_count: got %0d need 5", rx_count - rx0); end
        for (int i = 0; i < NUM_OPS; i++) begin
            compared++;
            if (rx_log.size() <= i || rx_log[i] !== op_addr[i]) begin
                mismatched++; $display("FAIL full_rx_addr%0d: got %h need %h", i, (rx_log.size() > i) ? rx_log[i] : 32'hx, op_addr[i]);
            end
        end
        compared++;
        if (core_pulses - c0 !== 1) begin mismatched++; $display("FAIL full_core_pulses: got %0d need 1", core_pulses - c0); end
        compared++;
        if (tx_count - tx0 !== 1) begin mismatched++; $display("FAIL full_tx_count: got %0d need 1", tx_count - tx0); end
        compared++;
        if (tx_addr_seen !== 32'hC000_0000) begin mismatched++; $display("FAIL full_tx_addr: got %h need %h", tx_addr_seen, 32'hC000_0000); end
        compared++;
        if (tx_data_seen !== 32'h0000_ABCD) begin mismatched++; $display("FAIL full_tx_data: got %h need %h", tx_data_seen, 32'hABCD); end
        compared++;
        if (operands !== {32'd5, 32'd4, 32'd3, 32'd2, 32'd1}) begin mismatched++; $display("FAIL full_operands: got %h", operands); end
        // go still asserted: must stay in DONE without re-fetching
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (status !== 32'h0000_0701 || rx_count - rx0 !== 5) begin mismatched++; $display("FAIL done_hold: got status %h reads %0d need 701 and 5", status, rx_count - rx0); end
        @(negedge clk) cmd = 32'd0;
        @(posedge clk); #1;
        compared++;
        if (status !== 32'h0000_0002) begin mismatched++; $display("FAIL full_back_idle: got %h need %h", status, 32'h2); end
    endtask

    task automatic test_partial_reload();
        int rx0, tx0;
        bit ok;
        for (int i = 0; i < NUM_OPS; i++) data_tab[i] = DATA_W'(32'hEE00 + i);
        data_tab[2] = 32'h0000_0033;
        bus.core_result = 32'h0000_1234;
        rx_log.delete();
        rx0 = rx_count; tx0 = tx_count;
        @(negedge clk) cmd = 32'h0000_0401;
        wait_state(4'd7, 4'd7, 300, ok);
        compared++;
        if (!ok || status !== 32'h0000_0701) begin mismatched++; $display("FAIL partial_done: got %h need %h", status, 32'h701); end
        compared++;
        if (rx_count - rx0 !== 1 || rx_log.size() < 1 || rx_log[0] !== op_addr[2]) begin
            mismatched++; $display("FAIL partial_fetch: got %0d reads need 1 read at %h", rx_count - rx0, op_addr[2]);
        end
        compared++;
        if (operands !== {32'd5, 32'd4, 32'h33, 32'd2, 32'd1}) begin mismatched++; $display("FAIL partial_operands: got %h", operands); end
        compared++;
        if (tx_count - tx0 !== 1 || tx_data_seen !== 32'h0000_1234) begin mismatched++; $display("FAIL partial_tx: got %0d writes data %h need 1 and 1234", tx_count - tx0, tx_data_seen); end
        @(negedge clk) cmd = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_mask_zero();
        int rx0, tx0, c0, n;
        bit ok;
        bus.core_result = 32'h0000_5A5A;
        rx0 = rx_count; tx0 = tx_count; c0 = core_pulses;
        @(negedge clk) cmd = 32'h0000_0001;
        @(posedge clk);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n++;
            if (bus.core_start) break;
        end
        compared++;
        if (n !== 5) begin mismatched++; $display("FAIL mask0_core_latency: got %0d cycles need 5", n); end
        wait_state(4'd7, 4'd7, 100, ok);
        compared++;
        if (!ok || status !== 32'h0000_0701) begin mismatched++; $display("FAIL mask0_done: got %h need %h", status, 32'h701); end
        compared++;
        if (rx_count - rx0 !== 0) begin mismatched++; $display("FAIL mask0_no_reads: got %0d need 0", rx_count - rx0); end
        compared++;
        if (core_pulses - c0 !== 1) begin mismatched++; $display("FAIL mask0_core_pulses: got %0d need 1", core_pulses - c0); end
        compared++;
        if (tx_count - tx0 !== 1 || tx_data_seen !== 32'h0000_5A5A) begin mismatched++; $display("FAIL mask0_tx: got %0d writes data %h need 1 and 5a5a", tx_count - tx0, tx_data_seen); end
        compared++;
        if (operands !== {32'd5, 32'd4, 32'h33, 32'd2, 32'd1}) begin mismatched++; $display("FAIL mask0_operands: got %h", operands); end
        @(negedge clk) cmd = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_dma_error();
        int rx0, c0;
        bit ok;
        for (int i = 0; i < NUM_OPS; i++) data_tab[i] = DATA_W'(32'h10 + i);
        err_op = 3;
        rx0 = rx_count; c0 = core_pulses;
        @(negedge clk) cmd = 32'h0000_1F01;
        wait_state(4'd8, 4'd7, 300, ok);
        compared++;
        if (!ok || status !== 32'h0000_0804) begin mismatched++; $display("FAIL dmaerr_status: got %h need %h", status, 32'h804); end
        compared++;
        if (operands !== {32'd5, 32'd4, 32'h12, 32'h11, 32'h10}) begin mismatched++; $display("FAIL dmaerr_operands: got %h", operands); end
        compared++;
        if (rx_count - rx0 !== 4) begin mismatched++; $display("FAIL dmaerr_reads: got %0d need 4", rx_count - rx0); end
        compared++;
        if (core_pulses - c0 !== 0) begin mismatched++; $display("FAIL dmaerr_no_core: got %0d need 0", core_pulses - c0); end
        @(negedge clk) cmd = 32'd0;
        err_op = -1;
        @(posedge clk); #1;
        compared++;
        if (status[11:8] !== 4'd0 || status[1] !== 1'b1) begin mismatched++; $display("FAIL dmaerr_back_idle: got %h need state 0 idle 1", status); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_timeout();
        int tx0, n;
        bit ok;
        core_hang = 1'b1;
        tx0 = tx_count;
        @(negedge clk) cmd = 32'h0000_0001;
        wait_state(4'd4, 4'd4, 50, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL timeout_enter_wait: status %h never reached COMPUTE_WAIT", status); end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            n++;
            if (status[11:8] == 4'd8) break;
        end
        compared++;
        if (n !== 16) begin mismatched++; $display("FAIL timeout_cycles: got %0d need 16", n); end
        compared++;
        if (status !== 32'h0000_0808) begin mismatched++; $display("FAIL timeout_status: got %h need %h", status, 32'h808); end
        compared++;
        if (tx_count - tx0 !== 0) begin mismatched++; $display("FAIL timeout_no_tx: got %0d need 0", tx_count - tx0); end
        @(negedge clk) cmd = 32'd0;
        core_hang = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (status[11:8] !== 4'd0) begin mismatched++; $display("FAIL timeout_back_idle: got %h need state 0", status); end
    endtask

    task automatic test_reset_mid_tx();
        int tx0;
        bit ok;
        bus.core_result = 32'h0000_0077;
        @(negedge clk) cmd = 32'h0000_0001;
        wait_state(4'd6, 4'd6, 100, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL rst_reach_txwait: status %h never reached TX_WAIT", status); end
        @(negedge clk);
        #2;
        reset = 1'b1;
        cmd   = 32'd0;
        #1;
        compared++;
        if (bus.dma_tx_start !== 1'b0 || status !== 32'h0000_0002) begin mismatched++; $display("FAIL rst_async: got tx_start %b status %h need 0 and 2", bus.dma_tx_start, status); end
        compared++;
        if (bus.dma_rx_address !== 32'd0) begin mismatched++; $display("FAIL rst_rx_address: got %h need 0", bus.dma_rx_address); end
        @(negedge clk) reset = 1'b0;
        repeat (8) @(posedge clk);
        tx0 = tx_count;
        @(negedge clk) cmd = 32'h0000_0001;
        wait_state(4'd7, 4'd8, 100, ok);
        compared++;
        if (!ok || status !== 32'h0000_0701) begin mismatched++; $display("FAIL rst_rerun_done: got %h need %h", status, 32'h701); end
        compared++;
        if (tx_count - tx0 !== 1 || tx_data_seen !== 32'h0000_0077) begin mismatched++; $display("FAIL rst_rerun_tx: got %0d writes data %h need 1 and 77", tx_count - tx0, tx_data_seen); end
        @(negedge clk) cmd = 32'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset   = 1'b1;
        cmd     = 32'd0;
        tx_addr = 32'hC000_0000;
        bus.core_result = '0;
        for (int i = 0; i < NUM_OPS; i++) op_addr[i] = 32'h1000_0000 + 32'(i * 16);
        for (int i = 0; i < NUM_OPS; i++) data_tab[i] = '0;
        test_reset();
        test_full_load();
        test_partial_reload();
        test_mask_zero();
        test_dma_error();
        test_timeout();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
